// File: rtl/inst_fetch_ctrl_if.sv
// Fetch-stage bus bundle: PC register link, instruction-memory request/response
// and the IF/ID handoff. The master side is the fetch controller.
interface inst_fetch_ctrl_if;
    logic [31:0] pc_cur;
    logic        pc_en;
    logic        flush;

    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;

    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_inst;
    logic [31:0] id_pc;

    modport master (
        input  pc_cur,
        input  flush,
        input  imem_req_ready,
        input  imem_resp_valid,
        input  imem_resp_data,
        input  id_ready,
        output pc_en,
        output imem_req_valid,
        output imem_req_addr,
        output id_valid,
        output id_inst,
        output id_pc
    );

    modport slave (
        output pc_cur,
        output flush,
        output imem_req_ready,
        output imem_resp_valid,
        output imem_resp_data,
        output id_ready,
        input  pc_en,
        input  imem_req_valid,
        input  imem_req_addr,
        input  id_valid,
        input  id_inst,
        input  id_pc
    );
endinterface

// File: rtl/inst_fetch_ctrl.sv
// Fetch-stage controller. Issues in-order instruction-memory reads at the
// current PC, tracks them in a small queue of {pc, inst, filled} entries and
// hands completed pairs to decode. A flush empties the queue and remembers how
// many responses are still owed so they can be thrown away when they arrive.
module inst_fetch_ctrl #(
    parameter int DEPTH = 2,
    parameter int PTR_W = 1
) (
    input  logic              clk,
    input  logic              rst,
    inst_fetch_ctrl_if.master bus
);

    localparam logic [PTR_W:0] DEPTH_P = DEPTH;
    localparam logic [PTR_W:0] ONE_P   = 1;

    logic [31:0]      ent_pc   [DEPTH];
    logic [31:0]      ent_inst [DEPTH];
    logic [DEPTH-1:0] ent_filled;

    // Extra MSB on each pointer separates full from empty.
    logic [PTR_W:0]   alloc_ptr;
    logic [PTR_W:0]   fill_ptr;
    logic [PTR_W:0]   rd_ptr;
    logic [PTR_W:0]   drop_cnt;

    logic [PTR_W:0]   occupancy;
    logic [PTR_W:0]   unfilled;
    logic [PTR_W:0]   drop_occ;
    logic [PTR_W:0]   drop_sum;
    logic [PTR_W:0]   drop_flush;
    logic [PTR_W-1:0] alloc_idx;
    logic [PTR_W-1:0] fill_idx;
    logic [PTR_W-1:0] rd_idx;
    logic             req_ok;
    logic             issue;
    logic             fill;
    logic             drop;
    logic             head_valid;
    logic             pop;

    // Queue bookkeeping and handshake qualifiers, all from registered state.
    always_comb begin
        alloc_idx  = alloc_ptr[PTR_W-1:0];
        fill_idx   = fill_ptr[PTR_W-1:0];
        rd_idx     = rd_ptr[PTR_W-1:0];
        occupancy  = alloc_ptr - rd_ptr;
        unfilled   = alloc_ptr - fill_ptr;
        // Stale responses still occupy memory-side slots, so they count
        // against the request budget until they have drained.
        drop_occ   = drop_cnt + occupancy;
        req_ok     = rst & ~bus.flush & (occupancy < DEPTH_P) & (drop_occ < DEPTH_P);
        issue      = req_ok & bus.imem_req_ready;
        drop       = bus.imem_resp_valid & (drop_cnt != '0);
        fill       = bus.imem_resp_valid & (drop_cnt == '0) & (unfilled != '0);
        head_valid = (occupancy != '0) & ent_filled[rd_idx];
        pop        = head_valid & bus.id_ready;
        // On flush every unfilled entry becomes a stale response; one arriving
        // in the flush cycle itself is the oldest of those and is consumed now.
        drop_sum   = drop_cnt + unfilled;
        drop_flush = drop_sum;
        if (bus.imem_resp_valid && (drop_sum != '0)) begin
            drop_flush = drop_sum - ONE_P;
        end
    end

    assign bus.imem_req_valid = req_ok;
    assign bus.imem_req_addr  = bus.pc_cur;
    // The flush cycle also advances the PC so it can load the redirect target.
    assign bus.pc_en          = issue | (bus.flush & rst);
    assign bus.id_valid       = head_valid;
    assign bus.id_inst        = ent_inst[rd_idx];
    assign bus.id_pc          = ent_pc[rd_idx];

    // Pointer, drop counter and entry updates; flush overrides issue/fill/pop.
    always_ff @(posedge clk) begin
        if (!rst) begin
            alloc_ptr  <= '0;
            fill_ptr   <= '0;
            rd_ptr     <= '0;
            drop_cnt   <= '0;
            ent_filled <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ent_pc[i]   <= '0;
                ent_inst[i] <= '0;
            end
        end else if (bus.flush) begin
            alloc_ptr  <= '0;
            fill_ptr   <= '0;
            rd_ptr     <= '0;
            ent_filled <= '0;
            drop_cnt   <= drop_flush;
        end else begin
            // Issue and fill never target the same slot: that would need
            // DEPTH unfilled entries, which already blocks issue.
            if (issue) begin
                ent_pc[alloc_idx]     <= bus.pc_cur;
                ent_filled[alloc_idx] <= 1'b0;
                alloc_ptr             <= alloc_ptr + ONE_P;
            end
            if (fill) begin
                ent_inst[fill_idx]   <= bus.imem_resp_data;
                ent_filled[fill_idx] <= 1'b1;
                fill_ptr             <= fill_ptr + ONE_P;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + ONE_P;
            end
            if (drop) begin
                drop_cnt <= drop_cnt - ONE_P;
            end
        end
    end

    // A response nobody is waiting for is ignored by the logic above.
    resp_expected_a : assert property (@(posedge clk) disable iff (!rst)
        bus.imem_resp_valid |-> ((drop_cnt != '0) || (unfilled != '0)));

endmodule
